// File: rtl/ebpf_alu_pkg.sv
// Shared constants and types for the eBPF add/sub scheduler.
// The 64-bit datapath is built from two passes through one 32-bit slice.
package ebpf_alu_pkg;

  localparam int unsigned HALF_W = 32;
  localparam int unsigned DATA_W = 2 * HALF_W;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    RESP
  } state_e;

  typedef logic req_id_t;

endpackage

// File: rtl/ebpf_addsub_sched_if.sv
// Request/response bundle between two requesters, one consumer and the scheduler.
interface ebpf_addsub_sched_if;
  import ebpf_alu_pkg::*;

  logic              req0_valid;
  logic              req0_ready;
  logic [DATA_W-1:0] req0_a;
  logic [DATA_W-1:0] req0_b;
  logic              req0_sub;
  logic              req0_is64;

  logic              req1_valid;
  logic              req1_ready;
  logic [DATA_W-1:0] req1_a;
  logic [DATA_W-1:0] req1_b;
  logic              req1_sub;
  logic              req1_is64;

  logic              rsp_valid;
  logic              rsp_ready;
  req_id_t           rsp_id;
  logic [DATA_W-1:0] rsp_result;
  logic              busy;

  modport master (
    output req0_valid, req0_a, req0_b, req0_sub, req0_is64,
    output req1_valid, req1_a, req1_b, req1_sub, req1_is64,
    output rsp_ready,
    input  req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, busy
  );

  modport slave (
    input  req0_valid, req0_a, req0_b, req0_sub, req0_is64,
    input  req1_valid, req1_a, req1_b, req1_sub, req1_is64,
    input  rsp_ready,
    output req0_ready, req1_ready, rsp_valid, rsp_id, rsp_result, busy
  );

endinterface

// File: rtl/add32_cin.sv
// Combinational HALF_W-bit adder with carry-in and carry-out.
module add32_cin
  import ebpf_alu_pkg::*;
(
  input  logic [HALF_W-1:0] a,
  input  logic [HALF_W-1:0] b,
  input  logic              cin,
  output logic [HALF_W-1:0] s,
  output logic              cout
);

  assign {cout, s} = {1'b0, a} + {1'b0, b} + {{HALF_W{1'b0}}, cin};

endmodule

// File: rtl/ebpf_addsub_sched.sv
// Round-robin scheduler sharing one 32-bit adder between two requesters; ALU64 ops take
// a low pass then a high pass with carry, ALU32 ops take one pass and zero-extend.
module ebpf_addsub_sched
  import ebpf_alu_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  ebpf_addsub_sched_if.slave   bus
);

  state_e            state_q, state_d;
  req_id_t           rr_ptr_q, rr_ptr_d;
  req_id_t           id_q, id_d;
  logic [DATA_W-1:0] a_q, a_d;
  logic [DATA_W-1:0] b_q, b_d;
  logic              sub_q, sub_d;
  logic              is64_q, is64_d;
  logic              carry_q, carry_d;
  logic [DATA_W-1:0] result_q, result_d;

  logic              idle;
  logic              any_valid;
  req_id_t           grant_id;
  logic              hi_pass;
  logic [HALF_W-1:0] slice_a, slice_b_raw, slice_b, slice_s;
  logic              slice_cin, slice_cout;

  // Lone valid wins outright; on contention rr_ptr picks.
  assign idle      = (state_q == IDLE);
  assign any_valid = bus.req0_valid | bus.req1_valid;
  assign grant_id  = bus.req1_valid & (~bus.req0_valid | rr_ptr_q);

  assign bus.req0_ready = idle & ~rst & bus.req0_valid & ~grant_id;
  assign bus.req1_ready = idle & ~rst & grant_id;
  assign bus.rsp_valid  = (state_q == RESP);
  assign bus.rsp_id     = id_q;
  assign bus.rsp_result = result_q;
  assign bus.busy       = ~idle;

  // Subtraction is A + ~B + 1; the +1 enters as the low-pass carry-in.
  assign hi_pass     = (state_q == HI);
  assign slice_a     = hi_pass ? a_q[DATA_W-1:HALF_W] : a_q[HALF_W-1:0];
  assign slice_b_raw = hi_pass ? b_q[DATA_W-1:HALF_W] : b_q[HALF_W-1:0];
  assign slice_b     = sub_q ? ~slice_b_raw : slice_b_raw;
  assign slice_cin   = hi_pass ? carry_q : sub_q;

  add32_cin u_add32_cin (
    .a    (slice_a),
    .b    (slice_b),
    .cin  (slice_cin),
    .s    (slice_s),
    .cout (slice_cout)
  );

  always_comb begin
    state_d  = state_q;
    rr_ptr_d = rr_ptr_q;
    id_d     = id_q;
    a_d      = a_q;
    b_d      = b_q;
    sub_d    = sub_q;
    is64_d   = is64_q;
    carry_d  = carry_q;
    result_d = result_q;

    unique case (state_q)
      IDLE: begin
        if (any_valid) begin
          id_d    = grant_id;
          a_d     = grant_id ? bus.req1_a : bus.req0_a;
          b_d     = grant_id ? bus.req1_b : bus.req0_b;
          sub_d   = grant_id ? bus.req1_sub : bus.req0_sub;
          is64_d  = grant_id ? bus.req1_is64 : bus.req0_is64;
          state_d = LO;
        end
      end
      LO: begin
        result_d[HALF_W-1:0] = slice_s;
        carry_d              = slice_cout;
        if (is64_q) begin
          state_d = HI;
        end else begin
          result_d[DATA_W-1:HALF_W] = '0;
          state_d                   = RESP;
        end
      end
      HI: begin
        // Top carry-out is dropped: results wrap mod 2^64.
        result_d[DATA_W-1:HALF_W] = slice_s;
        state_d                   = RESP;
      end
      RESP: begin
        if (bus.rsp_ready) begin
          rr_ptr_d = ~id_q;
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= IDLE;
      rr_ptr_q <= 1'b0;
      id_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      sub_q    <= 1'b0;
      is64_q   <= 1'b0;
      carry_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rr_ptr_q <= rr_ptr_d;
      id_q     <= id_d;
      a_q      <= a_d;
      b_q      <= b_d;
      sub_q    <= sub_d;
      is64_q   <= is64_d;
      carry_q  <= carry_d;
      result_q <= result_d;
    end
  end

endmodule

// File: tb/tb_ebpf_addsub_sched.sv
// Self-checking bench: an arithmetic/arbitration model checked every negedge,
// plus directed vectors with hand-computed results and latencies.
module tb_ebpf_addsub_sched;
  import ebpf_alu_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ebpf_addsub_sched_if bus ();

  ebpf_addsub_sched dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;
  int grants[$];

  task automatic chk64(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%016h, expected 0x%016h", name, act, exp);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %b, expected %b", name, act, exp);
    end
  endtask

  function automatic logic [63:0] alu(input logic [63:0] a, input logic [63:0] b,
                                      input logic sub, input logic is64);
    logic [63:0] r64;
    logic [31:0] r32;
    r64 = sub ? a - b : a + b;
    r32 = sub ? a[31:0] - b[31:0] : a[31:0] + b[31:0];
    return is64 ? r64 : {32'h0, r32};
  endfunction

  // Model: one op in flight, result due 2 (ALU32) or 3 (ALU64) edges after accept.
  bit          m_busy = 1'b0;
  bit          m_rr   = 1'b0;
  bit          m_id   = 1'b0;
  logic [63:0] m_res  = '0;
  int unsigned cyc    = 0;
  int unsigned m_due  = 0;
  bit          e0, e1, ev;

  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      chk1("rst_rsp_valid", bus.rsp_valid, 1'b0);
      chk1("rst_busy", bus.busy, 1'b0);
      chk1("rst_ready0", bus.req0_ready, 1'b0);
      chk1("rst_ready1", bus.req1_ready, 1'b0);
      chk1("rst_rsp_id", bus.rsp_id, 1'b0);
      m_busy = 1'b0;
      m_rr   = 1'b0;
    end else begin
      e0 = !m_busy && bus.req0_valid && (!bus.req1_valid || !m_rr);
      e1 = !m_busy && bus.req1_valid && (!bus.req0_valid || m_rr);
      ev = m_busy && (cyc >= m_due);
      chk1("m_ready0", bus.req0_ready, e0);
      chk1("m_ready1", bus.req1_ready, e1);
      chk1("m_busy", bus.busy, m_busy);
      chk1("m_rsp_valid", bus.rsp_valid, ev);
      if (ev) begin
        chk1("m_rsp_id", bus.rsp_id, m_id);
        chk64("m_rsp_result", bus.rsp_result, m_res);
      end
      if (ev && bus.rsp_ready) begin
        m_busy = 1'b0;
        m_rr   = !m_id;
      end else if (e0 || e1) begin
        m_busy = 1'b1;
        m_id   = e1;
        m_res  = e1 ? alu(bus.req1_a, bus.req1_b, bus.req1_sub, bus.req1_is64)
                    : alu(bus.req0_a, bus.req0_b, bus.req0_sub, bus.req0_is64);
        m_due  = cyc + ((e1 ? bus.req1_is64 : bus.req0_is64) ? 3 : 2);
      end
    end
  end

  task automatic load0(input int k);
    bus.req0_a    = 64'h0000_0001_FFFF_FFFF + 64'(k) * 64'h0000_0100_0000_0001;
    bus.req0_b    = 64'(k + 3);
    bus.req0_sub  = (k % 2) == 1;
    bus.req0_is64 = (k != 1);
  endtask

  task automatic load1(input int k);
    bus.req1_a    = 64'h8000_0000_0000_0000 - 64'(k);
    bus.req1_b    = 64'h0000_0000_8000_0000 + 64'(k);
    bus.req1_sub  = (k % 2) == 0;
    bus.req1_is64 = (k != 2);
  endtask

  // Both requesters hold valid until each has n ops accepted; grant order is recorded.
  task automatic run_both(input int n);
    int i0 = 0;
    int i1 = 0;
    int t  = 0;
    bit g0, g1;
    grants.delete();
    @(posedge clk); #1;
    load0(0);
    load1(0);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    while ((i0 < n || i1 < n) && t < 400) begin
      @(negedge clk);
      t++;
      g0 = bus.req0_ready && bus.req0_valid;
      g1 = bus.req1_ready && bus.req1_valid;
      @(posedge clk); #1;
      if (g0) begin
        grants.push_back(0);
        i0++;
        if (i0 < n) load0(i0);
        else bus.req0_valid = 1'b0;
      end
      if (g1) begin
        grants.push_back(1);
        i1++;
        if (i1 < n) load1(i1);
        else bus.req1_valid = 1'b0;
      end
    end
    chk64("both_done0", 64'(i0), 64'(n));
    chk64("both_done1", 64'(i1), 64'(n));
  endtask

  task automatic wait_idle();
    int t = 0;
    do begin
      @(negedge clk);
      t++;
    end while ((bus.busy || bus.rsp_valid) && t < 50);
    chk1("wait_idle", bus.busy, 1'b0);
  endtask

  task automatic issue(input string name, input bit id, input logic [63:0] a,
                       input logic [63:0] b, input bit sub, input bit is64,
                       input logic [63:0] exp_res, input int exp_lat);
    int  t = 0;
    int  lat = 0;
    bit  acc = 1'b0;
    bit  got = 1'b0;
    @(posedge clk); #1;
    if (id) begin
      bus.req1_a = a; bus.req1_b = b; bus.req1_sub = sub; bus.req1_is64 = is64;
      bus.req1_valid = 1'b1;
    end else begin
      bus.req0_a = a; bus.req0_b = b; bus.req0_sub = sub; bus.req0_is64 = is64;
      bus.req0_valid = 1'b1;
    end
    while (!acc && t < 20) begin
      @(negedge clk);
      t++;
      acc = id ? bus.req1_ready : bus.req0_ready;
    end
    chk1({name, "_accept"}, acc, 1'b1);
    @(posedge clk); #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    while (!got && lat < 20) begin
      @(negedge clk);
      lat++;
      got = bus.rsp_valid;
    end
    chk1({name, "_valid"}, got, 1'b1);
    chk64({name, "_latency"}, 64'(lat), 64'(exp_lat));
    chk64({name, "_result"}, bus.rsp_result, exp_res);
    chk1({name, "_id"}, bus.rsp_id, id);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: time limit reached, expected $finish earlier");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1;
    bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
    bus.req0_sub = 1'b0; bus.req0_is64 = 1'b0;
    bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
    bus.req1_sub = 1'b0; bus.req1_is64 = 1'b0;
    bus.rsp_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Contention from reset: grants alternate starting with requester 0.
    run_both(4);
    chk64("rr_grant_count", 64'(grants.size()), 64'd8);
    for (int k = 0; k < grants.size(); k++) chk64("rr_order", 64'(grants[k]), 64'(k % 2));
    wait_idle();

    issue("alu64_add", 1'b0, 64'h0000_0000_FFFF_FFFF, 64'h1, 1'b0, 1'b1,
          64'h0000_0001_0000_0000, 3);
    issue("alu32_sub_dirty", 1'b1, 64'hDEAD_0000_0000_0005, 64'hBEEF_0000_0000_0007, 1'b1, 1'b0,
          64'h0000_0000_FFFF_FFFE, 2);
    issue("wrap_add", 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'h1, 1'b0, 1'b1, 64'h0, 3);
    issue("wrap_sub", 1'b0, 64'h0, 64'h1, 1'b1, 1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 3);
    issue("borrow_sub", 1'b1, 64'h0000_0001_0000_0000, 64'h1, 1'b1, 1'b1,
          64'h0000_0000_FFFF_FFFF, 3);
    issue("alu32_wrap", 1'b1, 64'h1234_5678_FFFF_FFFF, 64'hFFFF_0000_0000_0001, 1'b0, 1'b0,
          64'h0, 2);
    wait_idle();

    // Back-pressure: RESP holds with stable outputs and no new accept.
    bus.rsp_ready = 1'b0;
    issue("bp", 1'b0, 64'h0000_0002_0000_0003, 64'h0000_0001_0000_0005, 1'b1, 1'b1,
          64'h0000_0000_FFFF_FFFE, 3);
    @(posedge clk); #1;
    bus.req1_a = 64'h5; bus.req1_b = 64'h6; bus.req1_sub = 1'b0; bus.req1_is64 = 1'b0;
    bus.req1_valid = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      chk1("bp_valid", bus.rsp_valid, 1'b1);
      chk64("bp_result", bus.rsp_result, 64'h0000_0000_FFFF_FFFE);
      chk1("bp_id", bus.rsp_id, 1'b0);
      chk1("bp_ready0", bus.req0_ready, 1'b0);
      chk1("bp_ready1", bus.req1_ready, 1'b0);
      chk1("bp_busy", bus.busy, 1'b1);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    chk1("bp_handshake", bus.rsp_valid, 1'b1);
    @(negedge clk);
    chk1("bp_single_hs", bus.rsp_valid, 1'b0);
    chk1("bp_next_grant", bus.req1_ready, 1'b1);
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    wait_idle();

    // Leave rr pointing at requester 1, then reset an ALU64 op while in HI.
    issue("pre_rst", 1'b0, 64'h7, 64'h8, 1'b0, 1'b0, 64'hF, 2);
    wait_idle();
    @(posedge clk); #1;
    bus.req1_a = 64'h1111_1111_2222_2222; bus.req1_b = 64'h1; bus.req1_sub = 1'b0;
    bus.req1_is64 = 1'b1; bus.req1_valid = 1'b1;
    begin
      int t = 0;
      bit acc = 1'b0;
      while (!acc && t < 20) begin
        @(negedge clk);
        t++;
        acc = bus.req1_ready;
      end
      chk1("midop_accept", acc, 1'b1);
    end
    @(posedge clk); #1;
    bus.req1_valid = 1'b0;
    @(posedge clk); #1;
    chk1("midop_busy_in_hi", bus.busy, 1'b1);
    bus.req0_valid = 1'b1;
    bus.req1_valid = 1'b1;
    rst = 1'b1;
    #1;
    chk1("midop_rsp_valid", bus.rsp_valid, 1'b0);
    chk1("midop_busy", bus.busy, 1'b0);
    chk1("midop_ready0", bus.req0_ready, 1'b0);
    chk1("midop_ready1", bus.req1_ready, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    bus.req0_valid = 1'b0;
    bus.req1_valid = 1'b0;
    rst = 1'b0;
    run_both(1);
    chk64("post_rst_grant_count", 64'(grants.size()), 64'd2);
    if (grants.size() >= 2) begin
      chk64("post_rst_first", 64'(grants[0]), 64'd0);
      chk64("post_rst_second", 64'(grants[1]), 64'd1);
    end
    wait_idle();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
